// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave shifter.
package spi_pkg;

  localparam int unsigned SPI_DATA_W       = 8;
  localparam int unsigned SPI_MIN_SCLK_DIV = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronises one asynchronous pin over SYNC_STAGES flops and flags its
// rising and falling edges one register later.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic d_i,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= level;
    end
  end

  assign rise_c_o = level & ~prev_q;
  assign fall_c_o = ~level & prev_q;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave byte engine: oversampled pins, all CPOL/CPHA modes, one-entry TX
// buffer and RX valid/ack. Define SPI_SLAVE_LSBFE_EN for selectable bit order.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              spe_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
`ifdef SPI_SLAVE_LSBFE_EN
  input  logic              lsbfe_i,
`endif
  input  logic              sclk_i,
  input  logic              ss_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ack_i,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              underrun_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s, sample_edge, shift_edge, lsb_in, abort, load_now;

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_ready_q, tx_ready_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  ptr_q, ptr_d;
  logic              done_q, done_d;
  logic              lsb_q, lsb_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;
  logic              busy_q, busy_d;

`ifdef SPI_SLAVE_LSBFE_EN
  assign lsb_in = lsbfe_i;
`else
  assign lsb_in = 1'b0;
`endif

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .d_i      (sclk_i),
    .rise_c_o (sclk_rise),
    .fall_c_o (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .d_i      (ss_n_i),
    .rise_c_o (ss_rise),
    .fall_c_o (ss_fall)
  );

  // MOSI is only synchronised; its stage count keeps it aligned with the SCLK edge pulses.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) mosi_sync_q <= '0;
    else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sample_edge = (cpol_i == cpha_i) ? sclk_rise : sclk_fall;
  assign shift_edge  = (cpol_i == cpha_i) ? sclk_fall : sclk_rise;
  assign abort       = (state_q != IDLE) && (ss_rise || !spe_i);

  function automatic logic tx_bit(input logic [DATA_W-1:0] sr,
                                  input logic [CNT_W-1:0]  idx,
                                  input logic              lsb);
    return lsb ? sr[idx] : sr[CNT_W'(DATA_W-1) - idx];
  endfunction

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      tx_buf_q   <= '0;
      tx_ready_q <= 1'b1;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      done_q     <= 1'b0;
      lsb_q      <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_buf_q   <= tx_buf_d;
      tx_ready_q <= tx_ready_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      done_q     <= done_d;
      lsb_q      <= lsb_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    done_d     = done_q;
    lsb_d      = lsb_q;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    load_now   = 1'b0;

    if (rx_ack_i) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end

    if (abort) begin
      state_d   = IDLE;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
          if (spe_i && ss_fall) state_d = LOAD;
        end
        LOAD: begin
          load_now = 1'b1;
          if (tx_ready_q) begin
            tx_sr_d    = '1;
            underrun_d = 1'b1;
          end else begin
            tx_sr_d = tx_buf_q;
          end
          tx_ready_d = 1'b1;
          lsb_d      = lsb_in;
          miso_d     = tx_bit(tx_sr_d, '0, lsb_in);
          miso_oe_d  = 1'b1;
          cnt_d      = '0;
          ptr_d      = '0;
          done_d     = 1'b0;
          state_d    = SHIFT;
        end
        SHIFT: begin
          if (done_q) begin
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ack_i) overrun_d = 1'b1;
            done_d     = 1'b0;
            state_d    = LOAD;
          end else begin
            if (sample_edge) begin
              rx_sr_d = lsb_q ? {mosi_s, rx_sr_q[DATA_W-1:1]}
                              : {rx_sr_q[DATA_W-2:0], mosi_s};
              cnt_d   = cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(DATA_W-1)) done_d = 1'b1;
            end
            // Advance only past bits already sampled: covers the CPHA=1 leading
            // edge and the trailing edge of the previous byte in back-to-back mode.
            if (shift_edge && (ptr_q < cnt_q)) begin
              ptr_d  = ptr_q + CNT_W'(1);
              miso_d = tx_bit(tx_sr_q, ptr_d, lsb_q);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // The buffer frees up in LOAD, so a same-cycle write is accepted.
    if (tx_valid_i && (tx_ready_q || load_now)) begin
      tx_buf_d   = tx_data_i;
      tx_ready_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign miso_o     = miso_q;
  assign miso_oe_o  = miso_oe_q;
  assign tx_ready_o = tx_ready_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign overrun_o  = overrun_q;
  assign underrun_o = underrun_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter acting as an SPI master bit-banging the pins.
module tb_spi_slave_shifter;
  import spi_pkg::*;

  localparam int unsigned H    = SPI_MIN_SCLK_DIV / 2;
  localparam int unsigned SYNC = 2;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       spe_i, cpol_i, cpha_i, lsbfe_i;
  logic       sclk_i, ss_n_i, mosi_i;
  logic       miso_o, miso_oe_o;
  logic [7:0] tx_data_i;
  logic       tx_valid_i, tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, rx_ack_i, busy_o, overrun_o, underrun_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mi, mi2;

  spi_slave_shifter #(.DATA_W(8), .SYNC_STAGES(SYNC)) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .spe_i      (spe_i),
    .cpol_i     (cpol_i),
    .cpha_i     (cpha_i),
`ifdef SPI_SLAVE_LSBFE_EN
    .lsbfe_i    (lsbfe_i),
`endif
    .sclk_i     (sclk_i),
    .ss_n_i     (ss_n_i),
    .mosi_i     (mosi_i),
    .miso_o     (miso_o),
    .miso_oe_o  (miso_oe_o),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ack_i   (rx_ack_i),
    .busy_o     (busy_o),
    .overrun_o  (overrun_o),
    .underrun_o (underrun_o)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge PCLK);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    @(negedge PCLK);
    tx_valid_i = 1'b0;
  endtask

  task automatic ack_rx();
    @(negedge PCLK);
    rx_ack_i = 1'b1;
    @(negedge PCLK);
    rx_ack_i = 1'b0;
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    cpol_i = pol;
    cpha_i = pha;
    sclk_i = pol;
    wait_n(8);
  endtask

  task automatic sel();
    ss_n_i = 1'b0;
    wait_n(H);
  endtask

  task automatic desel();
    wait_n(H);
    ss_n_i = 1'b1;
    wait_n(H + 4);
  endtask

  // Master side: drives MOSI/SCLK and samples MISO just before each sample edge.
  task automatic spi_bits(input logic lsb, input logic [7:0] mo, input int nbits,
                          output logic [7:0] rd);
    int idx;
    rd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb ? i : 7 - i;
      if (!cpha_i) begin
        mosi_i  = mo[idx];
        wait_n(H);
        rd[idx] = miso_o;
        sclk_i  = ~cpol_i;
        wait_n(H);
        sclk_i  = cpol_i;
      end else begin
        sclk_i  = ~cpol_i;
        mosi_i  = mo[idx];
        wait_n(H);
        rd[idx] = miso_o;
        sclk_i  = cpol_i;
        wait_n(H);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET = 1'b1; spe_i = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0; lsbfe_i = 1'b0;
    sclk_i = 1'b0; ss_n_i = 1'b1; mosi_i = 1'b0;
    tx_data_i = 8'h00; tx_valid_i = 1'b0; rx_ack_i = 1'b0;
    wait_n(3);
    PRESET = 1'b0;
    wait_n(2);

    check_eq("rst_miso",     miso_o,     0);
    check_eq("rst_miso_oe",  miso_oe_o,  0);
    check_eq("rst_tx_ready", tx_ready_o, 1);
    check_eq("rst_rx_data",  rx_data_o,  0);
    check_eq("rst_rx_valid", rx_valid_o, 0);
    check_eq("rst_busy",     busy_o,     0);
    check_eq("rst_overrun",  overrun_o,  0);
    check_eq("rst_underrun", underrun_o, 0);

    // Mode 0, single byte
    set_mode(1'b0, 1'b0);
    tx_write(8'h3C);
    check_eq("m0_tx_ready_full", tx_ready_o, 0);
    sel();
    check_eq("m0_busy",          busy_o,     1);
    check_eq("m0_miso_oe",       miso_oe_o,  1);
    check_eq("m0_tx_ready_load", tx_ready_o, 1);
    spi_bits(1'b0, 8'hA5, 8, mi);
    wait_n(2);
    check_eq("m0_rx_data",  rx_data_o,  8'hA5);
    check_eq("m0_rx_valid", rx_valid_o, 1);
    check_eq("m0_miso",     mi,         8'h3C);
    check_eq("m0_underrun_next_load", underrun_o, 1);
    desel();
    check_eq("m0_busy_idle",  busy_o,    0);
    check_eq("m0_oe_idle",    miso_oe_o, 0);
    check_eq("m0_miso_idle",  miso_o,    0);
    ack_rx();
    check_eq("m0_ack_valid",    rx_valid_o, 0);
    check_eq("m0_ack_underrun", underrun_o, 0);

    // Mode 3
    set_mode(1'b1, 1'b1);
    tx_write(8'hC3);
    check_eq("m3_oe_before", miso_oe_o, 0);
    sel();
    check_eq("m3_oe_during", miso_oe_o, 1);
    spi_bits(1'b0, 8'h5A, 8, mi);
    desel();
    check_eq("m3_rx_data",  rx_data_o, 8'h5A);
    check_eq("m3_miso",     mi,        8'hC3);
    check_eq("m3_oe_after", miso_oe_o, 0);
    ack_rx();

    // Back-to-back with ss held low, no ack between bytes
    set_mode(1'b0, 1'b0);
    tx_write(8'h11);
    sel();
    tx_write(8'h22);
    spi_bits(1'b0, 8'h81, 8, mi);
    check_eq("b2b_rx1",      rx_data_o, 8'h81);
    check_eq("b2b_ovr1",     overrun_o, 0);
    spi_bits(1'b0, 8'h7E, 8, mi2);
    wait_n(2);
    check_eq("b2b_rx2",      rx_data_o, 8'h7E);
    check_eq("b2b_ovr2",     overrun_o, 1);
    check_eq("b2b_miso1",    mi,        8'h11);
    check_eq("b2b_miso2",    mi2,       8'h22);
    desel();
    ack_rx();
    check_eq("b2b_ovr_ack",  overrun_o, 0);

    // Abort after 3 SCLK cycles, then a full byte
    sel();
    spi_bits(1'b0, 8'hFF, 3, mi);
    ss_n_i = 1'b1;
    wait_n(SYNC + 2);
    check_eq("abort_busy",     busy_o,     0);
    check_eq("abort_rx_valid", rx_valid_o, 0);
    check_eq("abort_oe",       miso_oe_o,  0);
    wait_n(H);
    sel();
    spi_bits(1'b0, 8'hF0, 8, mi);
    desel();
    check_eq("abort_next_rx",    rx_data_o,  8'hF0);
    check_eq("abort_next_valid", rx_valid_o, 1);
    ack_rx();

    // Underrun: empty TX buffer sends all ones
    sel();
    spi_bits(1'b0, 8'h00, 8, mi);
    desel();
    check_eq("ur_miso",     mi,         8'hFF);
    check_eq("ur_flag",     underrun_o, 1);
    check_eq("ur_rx",       rx_data_o,  8'h00);
    check_eq("ur_valid",    rx_valid_o, 1);
    ack_rx();
    check_eq("ur_ack_valid", rx_valid_o, 0);
    check_eq("ur_ack_flag",  underrun_o, 0);

    // Slave disable while selected
    sel();
    spe_i = 1'b0;
    wait_n(2);
    check_eq("spe_off_busy", busy_o,    0);
    check_eq("spe_off_oe",   miso_oe_o, 0);
    spe_i = 1'b1;
    desel();
    ack_rx();

`ifdef SPI_SLAVE_LSBFE_EN
    // Mode 1, LSB first
    set_mode(1'b0, 1'b1);
    lsbfe_i = 1'b1;
    tx_write(8'h80);
    sel();
    spi_bits(1'b1, 8'h01, 8, mi);
    desel();
    check_eq("lsb_rx",   rx_data_o, 8'h01);
    check_eq("lsb_miso", mi,        8'h80);
    ack_rx();
    lsbfe_i = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
